// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
//
// Pipeline sequencer for the five-stage core. Produces the hold (stall) and
// clear (flush) controls for the fetch/decode/execute/memory stage registers,
// the operand forwarding selects for the execute stage, and runs the
// cache-miss state machine that freezes the pipeline while the single refill
// port serves either the instruction cache or the data cache.
//
// Parameters
//   CNT_WIDTH   width of the saturating stall-cycle performance counter
//   REG_ADDR_W  register address width
//
// Ports
//   i_clk                       clock, rising edge
//   i_arst                      asynchronous active-low reset
//   i_rs1_addr_d, i_rs2_addr_d  source registers of the instruction in decode
//   i_rs1_addr_e, i_rs2_addr_e  source registers of the instruction in execute
//   i_rd_addr_e, i_load_instr_e destination / load flag, execute stage
//   i_rd_addr_m, i_reg_we_m     destination / write enable, memory stage
//   i_rd_addr_w, i_reg_we_w     destination / write enable, writeback stage
//   i_branch_taken_e            redirect resolved in execute
//   i_icache_miss, i_dcache_miss  level-sensitive miss indications
//   i_mem_ack                   single-cycle refill-complete pulse
//   o_stall_*                   hold the corresponding stage register
//   o_flush_decode/exec         clear the stage register (bubble)
//   o_forward_rs1/rs2           00 regfile, 01 writeback, 10 memory stage
//   o_mem_req, o_mem_sel        refill request; sel 0 = icache, 1 = dcache
//   o_stall_count               saturating count of fetch-stall cycles
// ---------------------------------------------------------------------------
module hazard_controller #(
    parameter int CNT_WIDTH  = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr_d,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr_d,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr_e,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr_e,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_e,
    input  logic                  i_load_instr_e,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_m,
    input  logic                  i_reg_we_m,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_w,
    input  logic                  i_reg_we_w,
    input  logic                  i_branch_taken_e,
    input  logic                  i_icache_miss,
    input  logic                  i_dcache_miss,
    input  logic                  i_mem_ack,
    output logic                  o_stall_fetch,
    output logic                  o_stall_decode,
    output logic                  o_stall_exec,
    output logic                  o_stall_mem,
    output logic                  o_flush_decode,
    output logic                  o_flush_exec,
    output logic [1:0]            o_forward_rs1,
    output logic [1:0]            o_forward_rs2,
    output logic                  o_mem_req,
    output logic                  o_mem_sel,
    output logic [CNT_WIDTH-1:0]  o_stall_count
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_I_MISS = 2'd1,
        ST_D_MISS = 2'd2
    } state_t;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // A producer hits a consumer only when it writes a real register (x0 is
    // hard-wired to zero and must never be treated as a dependency).
    function automatic logic reg_hit(
        input logic [REG_ADDR_W-1:0] rd,
        input logic                  we,
        input logic [REG_ADDR_W-1:0] rs
    );
        return we && (rd != REG_ZERO) && (rd == rs);
    endfunction

    // Forward select for one source operand; the memory stage holds the
    // younger result, so it wins over writeback.
    function automatic logic [1:0] fwd_select(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rd_m,
        input logic                  we_m,
        input logic [REG_ADDR_W-1:0] rd_w,
        input logic                  we_w
    );
        logic [1:0] sel;
        if (reg_hit(rd_m, we_m, rs)) begin
            sel = 2'b10;
        end else if (reg_hit(rd_w, we_w, rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    state_t               state_r;
    state_t               state_next_s;
    logic                 mem_req_r;
    logic                 mem_sel_r;
    logic                 mem_req_next_s;
    logic                 mem_sel_next_s;
    logic                 load_use_s;
    logic [CNT_WIDTH-1:0] stall_count_r;

    // Load in execute whose result is needed by the instruction in decode.
    always_comb begin
        load_use_s = reg_hit(i_rd_addr_e, i_load_instr_e, i_rs1_addr_d) ||
                     reg_hit(i_rd_addr_e, i_load_instr_e, i_rs2_addr_d);
    end

    // Miss state register.
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Miss next-state logic: the data miss belongs to the older instruction
    // and wins; an instruction miss on a redirected (wrong-path) fetch is
    // dropped. Acks arriving in RUN have no effect.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (i_dcache_miss) begin
                    state_next_s = ST_D_MISS;
                end else if (i_icache_miss && !i_branch_taken_e) begin
                    state_next_s = ST_I_MISS;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_I_MISS, ST_D_MISS: begin
                if (i_mem_ack) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // Stage control outputs. While refilling, everything holds and nothing
    // is flushed so a pending redirect stays frozen in execute. In RUN a
    // taken branch discards the younger instructions, which makes any
    // load-use stall on them pointless, so the flush overrides the stall.
    always_comb begin
        o_stall_fetch  = 1'b0;
        o_stall_decode = 1'b0;
        o_stall_exec   = 1'b0;
        o_stall_mem    = 1'b0;
        o_flush_decode = 1'b0;
        o_flush_exec   = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (i_branch_taken_e) begin
                    o_flush_decode = 1'b1;
                    o_flush_exec   = 1'b1;
                end else if (load_use_s) begin
                    o_stall_fetch  = 1'b1;
                    o_stall_decode = 1'b1;
                    o_flush_exec   = 1'b1;
                end else begin
                    o_flush_exec   = 1'b0;
                end
            end
            ST_I_MISS, ST_D_MISS: begin
                o_stall_fetch  = 1'b1;
                o_stall_decode = 1'b1;
                o_stall_exec   = 1'b1;
                o_stall_mem    = 1'b1;
            end
            default: begin
                o_stall_fetch  = 1'b0;
            end
        endcase
    end

    // Refill request decode from the next state so the request flops line
    // up with the state register (request visible the cycle after the miss).
    always_comb begin
        mem_req_next_s = 1'b0;
        mem_sel_next_s = 1'b0;
        case (state_next_s)
            ST_I_MISS: begin
                mem_req_next_s = 1'b1;
                mem_sel_next_s = 1'b0;
            end
            ST_D_MISS: begin
                mem_req_next_s = 1'b1;
                mem_sel_next_s = 1'b1;
            end
            default: begin
                mem_req_next_s = 1'b0;
                mem_sel_next_s = 1'b0;
            end
        endcase
    end

    // Refill request registers; cleared asynchronously so a reset drops the
    // request mid-refill without waiting for a clock.
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            mem_req_r <= 1'b0;
            mem_sel_r <= 1'b0;
        end else begin
            mem_req_r <= mem_req_next_s;
            mem_sel_r <= mem_sel_next_s;
        end
    end

    // Saturating count of cycles in which fetch is held.
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            stall_count_r <= {CNT_WIDTH{1'b0}};
        end else if (o_stall_fetch && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + CNT_ONE;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    // Operand forwarding is purely combinational on the execute operands.
    always_comb begin
        o_forward_rs1 = fwd_select(i_rs1_addr_e, i_rd_addr_m, i_reg_we_m,
                                   i_rd_addr_w, i_reg_we_w);
        o_forward_rs2 = fwd_select(i_rs2_addr_e, i_rd_addr_m, i_reg_we_m,
                                   i_rd_addr_w, i_reg_we_w);
    end

    assign o_mem_req     = mem_req_r;
    assign o_mem_sel     = mem_sel_r;
    assign o_stall_count = stall_count_r;

endmodule

// File: tb/tb_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_controller
//
// Directed bench for hazard_controller with a 4-bit stall counter so that
// saturation is reachable. Inputs change 1 ns after the rising edge and the
// outputs are sampled 1 ns later, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_hazard_controller;

    localparam int CW = 4;
    localparam int AW = 5;

    logic          i_clk;
    logic          i_arst;
    logic [AW-1:0] i_rs1_addr_d, i_rs2_addr_d;
    logic [AW-1:0] i_rs1_addr_e, i_rs2_addr_e;
    logic [AW-1:0] i_rd_addr_e;
    logic          i_load_instr_e;
    logic [AW-1:0] i_rd_addr_m;
    logic          i_reg_we_m;
    logic [AW-1:0] i_rd_addr_w;
    logic          i_reg_we_w;
    logic          i_branch_taken_e;
    logic          i_icache_miss, i_dcache_miss, i_mem_ack;
    logic          o_stall_fetch, o_stall_decode, o_stall_exec, o_stall_mem;
    logic          o_flush_decode, o_flush_exec;
    logic [1:0]    o_forward_rs1, o_forward_rs2;
    logic          o_mem_req, o_mem_sel;
    logic [CW-1:0] o_stall_count;

    int n_checks = 0;
    int n_errors = 0;

    hazard_controller #(.CNT_WIDTH(CW), .REG_ADDR_W(AW)) dut (
        .i_clk            (i_clk),
        .i_arst           (i_arst),
        .i_rs1_addr_d     (i_rs1_addr_d),
        .i_rs2_addr_d     (i_rs2_addr_d),
        .i_rs1_addr_e     (i_rs1_addr_e),
        .i_rs2_addr_e     (i_rs2_addr_e),
        .i_rd_addr_e      (i_rd_addr_e),
        .i_load_instr_e   (i_load_instr_e),
        .i_rd_addr_m      (i_rd_addr_m),
        .i_reg_we_m       (i_reg_we_m),
        .i_rd_addr_w      (i_rd_addr_w),
        .i_reg_we_w       (i_reg_we_w),
        .i_branch_taken_e (i_branch_taken_e),
        .i_icache_miss    (i_icache_miss),
        .i_dcache_miss    (i_dcache_miss),
        .i_mem_ack        (i_mem_ack),
        .o_stall_fetch    (o_stall_fetch),
        .o_stall_decode   (o_stall_decode),
        .o_stall_exec     (o_stall_exec),
        .o_stall_mem      (o_stall_mem),
        .o_flush_decode   (o_flush_decode),
        .o_flush_exec     (o_flush_exec),
        .o_forward_rs1    (o_forward_rs1),
        .o_forward_rs2    (o_forward_rs2),
        .o_mem_req        (o_mem_req),
        .o_mem_sel        (o_mem_sel),
        .o_stall_count    (o_stall_count)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_rs1_addr_d     = 5'd0;
        i_rs2_addr_d     = 5'd0;
        i_rs1_addr_e     = 5'd0;
        i_rs2_addr_e     = 5'd0;
        i_rd_addr_e      = 5'd0;
        i_load_instr_e   = 1'b0;
        i_rd_addr_m      = 5'd0;
        i_reg_we_m       = 1'b0;
        i_rd_addr_w      = 5'd0;
        i_reg_we_w       = 1'b0;
        i_branch_taken_e = 1'b0;
        i_icache_miss    = 1'b0;
        i_dcache_miss    = 1'b0;
        i_mem_ack        = 1'b0;
    endtask

    initial begin
        clear_inputs();
        i_arst = 1'b0;
        #2;
        // ---- reset state
        check_eq("rst_mem_req",   32'(o_mem_req),      32'd0);
        check_eq("rst_mem_sel",   32'(o_mem_sel),      32'd0);
        check_eq("rst_count",     32'(o_stall_count),  32'd0);
        check_eq("rst_stall_f",   32'(o_stall_fetch),  32'd0);
        check_eq("rst_flush_d",   32'(o_flush_decode), 32'd0);
        check_eq("rst_flush_e",   32'(o_flush_exec),   32'd0);
        check_eq("rst_fwd1",      32'(o_forward_rs1),  32'd0);
        #20 i_arst = 1'b1;
        next_cycle();

        // ---- load-use on rs2
        i_load_instr_e = 1'b1; i_rd_addr_e = 5'd5; i_rs2_addr_d = 5'd5; i_rs1_addr_d = 5'd1;
        #1;
        check_eq("lu_stall_f",  32'(o_stall_fetch),  32'd1);
        check_eq("lu_stall_d",  32'(o_stall_decode), 32'd1);
        check_eq("lu_flush_e",  32'(o_flush_exec),   32'd1);
        check_eq("lu_flush_d",  32'(o_flush_decode), 32'd0);
        check_eq("lu_stall_e",  32'(o_stall_exec),   32'd0);
        check_eq("lu_stall_m",  32'(o_stall_mem),    32'd0);
        check_eq("lu_mem_req",  32'(o_mem_req),      32'd0);
        next_cycle();
        i_load_instr_e = 1'b0;
        #1;
        check_eq("lu_release",  32'(o_stall_fetch),  32'd0);
        check_eq("lu_count",    32'(o_stall_count),  32'd1);

        // ---- rd = 0 never stalls
        i_load_instr_e = 1'b1; i_rd_addr_e = 5'd0; i_rs1_addr_d = 5'd0; i_rs2_addr_d = 5'd0;
        #1;
        check_eq("lu0_stall_f", 32'(o_stall_fetch),  32'd0);
        check_eq("lu0_flush_e", 32'(o_flush_exec),   32'd0);

        // ---- load-use on rs1
        next_cycle();
        i_rd_addr_e = 5'd3; i_rs1_addr_d = 5'd3; i_rs2_addr_d = 5'd4;
        #1;
        check_eq("lu1_stall_d", 32'(o_stall_decode), 32'd1);
        check_eq("lu1_count",   32'(o_stall_count),  32'd1);

        // ---- branch together with load-use: flush only
        next_cycle();
        i_rd_addr_e = 5'd6; i_rs1_addr_d = 5'd6; i_branch_taken_e = 1'b1;
        #1;
        check_eq("bl_stall_f",  32'(o_stall_fetch),  32'd0);
        check_eq("bl_stall_d",  32'(o_stall_decode), 32'd0);
        check_eq("bl_flush_d",  32'(o_flush_decode), 32'd1);
        check_eq("bl_flush_e",  32'(o_flush_exec),   32'd1);
        check_eq("bl_count",    32'(o_stall_count),  32'd2);
        next_cycle();
        clear_inputs();
        #1;
        check_eq("bl_count2",   32'(o_stall_count),  32'd2);

        // ---- forwarding priority
        i_rs1_addr_e = 5'd7; i_rd_addr_m = 5'd7; i_rd_addr_w = 5'd7;
        i_reg_we_m = 1'b1; i_reg_we_w = 1'b1;
        #1;
        check_eq("fwd1_mem",    32'(o_forward_rs1),  32'd2);
        i_reg_we_m = 1'b0;
        #1;
        check_eq("fwd1_wb",     32'(o_forward_rs1),  32'd1);
        i_reg_we_w = 1'b0;
        #1;
        check_eq("fwd1_rf",     32'(o_forward_rs1),  32'd0);
        i_rs2_addr_e = 5'd9; i_rd_addr_m = 5'd9; i_rd_addr_w = 5'd9;
        i_reg_we_m = 1'b1; i_reg_we_w = 1'b1;
        #1;
        check_eq("fwd2_mem",    32'(o_forward_rs2),  32'd2);
        i_rs2_addr_e = 5'd0; i_rd_addr_m = 5'd0; i_rd_addr_w = 5'd0;
        #1;
        check_eq("fwd2_x0",     32'(o_forward_rs2),  32'd0);
        clear_inputs();

        // ---- wrong-path instruction miss
        next_cycle();
        i_icache_miss = 1'b1; i_branch_taken_e = 1'b1;
        #1;
        check_eq("wp_flush_d",  32'(o_flush_decode), 32'd1);
        check_eq("wp_flush_e",  32'(o_flush_exec),   32'd1);
        check_eq("wp_stall_f",  32'(o_stall_fetch),  32'd0);
        next_cycle();
        i_icache_miss = 1'b0; i_branch_taken_e = 1'b0;
        #1;
        check_eq("wp_mem_req",  32'(o_mem_req),      32'd0);

        // ---- arbitration: both misses, data first
        i_icache_miss = 1'b1; i_dcache_miss = 1'b1;
        #1;
        check_eq("arb_n_req",   32'(o_mem_req),      32'd0);
        check_eq("arb_n_stall", 32'(o_stall_fetch),  32'd0);
        next_cycle();
        i_dcache_miss = 1'b0;
        #1;
        check_eq("arb_d_req",   32'(o_mem_req),      32'd1);
        check_eq("arb_d_sel",   32'(o_mem_sel),      32'd1);
        check_eq("arb_d_stf",   32'(o_stall_fetch),  32'd1);
        check_eq("arb_d_stm",   32'(o_stall_mem),    32'd1);
        next_cycle();
        next_cycle();
        next_cycle();
        i_mem_ack = 1'b1;
        #1;
        check_eq("arb_ack_req", 32'(o_mem_req),      32'd1);
        check_eq("arb_ack_sel", 32'(o_mem_sel),      32'd1);
        next_cycle();
        i_mem_ack = 1'b0;
        #1;
        check_eq("arb_run_req", 32'(o_mem_req),      32'd0);
        check_eq("arb_run_stf", 32'(o_stall_fetch),  32'd0);
        check_eq("arb_count",   32'(o_stall_count),  32'd6);
        next_cycle();
        #1;
        check_eq("arb_i_req",   32'(o_mem_req),      32'd1);
        check_eq("arb_i_sel",   32'(o_mem_sel),      32'd0);
        check_eq("arb_i_std",   32'(o_stall_decode), 32'd1);
        next_cycle();
        i_mem_ack = 1'b1; i_icache_miss = 1'b0;
        #1;
        check_eq("arb_iack_req", 32'(o_mem_req),     32'd1);
        next_cycle();
        i_mem_ack = 1'b0;
        #1;
        check_eq("arb_done_req", 32'(o_mem_req),     32'd0);
        check_eq("arb_count2",  32'(o_stall_count),  32'd8);

        // ---- stray ack in RUN is ignored
        i_mem_ack = 1'b1;
        next_cycle();
        i_mem_ack = 1'b0;
        #1;
        check_eq("ack_run_req", 32'(o_mem_req),      32'd0);

        // ---- redirect under freeze
        i_dcache_miss = 1'b1;
        next_cycle();
        i_dcache_miss = 1'b0; i_branch_taken_e = 1'b1;
        #1;
        check_eq("frz_flush_d", 32'(o_flush_decode), 32'd0);
        check_eq("frz_flush_e", 32'(o_flush_exec),   32'd0);
        check_eq("frz_stall_f", 32'(o_stall_fetch),  32'd1);
        check_eq("frz_stall_e", 32'(o_stall_exec),   32'd1);
        next_cycle();
        i_mem_ack = 1'b1;
        #1;
        check_eq("frz2_flush_e", 32'(o_flush_exec),  32'd0);
        check_eq("frz2_stall_m", 32'(o_stall_mem),   32'd1);
        next_cycle();
        i_mem_ack = 1'b0;
        #1;
        check_eq("frz_run_fd",  32'(o_flush_decode), 32'd1);
        check_eq("frz_run_fe",  32'(o_flush_exec),   32'd1);
        check_eq("frz_run_sf",  32'(o_stall_fetch),  32'd0);
        check_eq("frz_run_req", 32'(o_mem_req),      32'd0);
        check_eq("frz_count",   32'(o_stall_count),  32'd10);
        i_branch_taken_e = 1'b0;

        // ---- counter saturation: 20 frozen cycles
        next_cycle();
        i_dcache_miss = 1'b1;
        next_cycle();
        i_dcache_miss = 1'b0;
        repeat (20) next_cycle();
        #1;
        check_eq("sat_count",   32'(o_stall_count),  32'd15);
        check_eq("sat_req",     32'(o_mem_req),      32'd1);
        i_mem_ack = 1'b1;
        next_cycle();
        i_mem_ack = 1'b0;
        #1;
        check_eq("sat_hold",    32'(o_stall_count),  32'd15);
        check_eq("sat_run_req", 32'(o_mem_req),      32'd0);

        // ---- reset in the middle of an instruction refill
        i_icache_miss = 1'b1;
        next_cycle();
        i_icache_miss = 1'b0;
        #1;
        check_eq("mr_req",      32'(o_mem_req),      32'd1);
        check_eq("mr_sel",      32'(o_mem_sel),      32'd0);
        #1 i_arst = 1'b0;
        #1;
        check_eq("mr_req_drop", 32'(o_mem_req),      32'd0);
        check_eq("mr_count",    32'(o_stall_count),  32'd0);
        check_eq("mr_stall_f",  32'(o_stall_fetch),  32'd0);
        next_cycle();
        i_arst = 1'b1;
        next_cycle();
        #1;
        check_eq("mr_post_req", 32'(o_mem_req),      32'd0);
        check_eq("mr_post_cnt", 32'(o_stall_count),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencer for the five-stage core. It generates stall, flush and forwarding controls for the fetch, decode, execute and memory stages. It detects load-use hazards and branch redirects. It also runs a cache-miss state machine that freezes the pipeline and arbitrates one refill port between the instruction cache and the data cache. It sits beside the datapath and drives the clear/enable inputs of the decode and execute pipeline registers.

## Interface
- CNT_WIDTH, 32, width of the stall-cycle performance counter
- REG_ADDR_W, 5, register address width
- i_clk  in  1  clock; all state changes on the rising edge
- i_arst  in  1  asynchronous, active-low reset
- i_rs1_addr_d, i_rs2_addr_d  in  REG_ADDR_W  source registers of the instruction in decode
- i_rs1_addr_e, i_rs2_addr_e  in  REG_ADDR_W  source registers held in the decode pipeline register (execute stage)
- i_rd_addr_e, i_load_instr_e  in  REG_ADDR_W, 1  destination register and load flag, execute stage
- i_rd_addr_m, i_reg_we_m  in  REG_ADDR_W, 1  destination register and write enable, memory stage
- i_rd_addr_w, i_reg_we_w  in  REG_ADDR_W, 1  destination register and write enable, writeback stage
- i_branch_taken_e  in  1  branch or jump redirect resolved in execute
- i_icache_miss, i_dcache_miss  in  1  miss indications, level-sensitive
- i_mem_ack  in  1  refill complete, single-cycle pulse
- o_stall_fetch, o_stall_decode, o_stall_exec, o_stall_mem  out  1  hold the stage register
- o_flush_decode, o_flush_exec  out  1  clear the stage register (insert a bubble)
- o_forward_rs1, o_forward_rs2  out  2  00 = register file, 01 = writeback, 10 = memory stage
- o_mem_req, o_mem_sel  out  1, 1  refill request; sel 0 = instruction cache, 1 = data cache
- o_stall_count  out  CNT_WIDTH  count of cycles with o_stall_fetch high, saturating

## Operation
- FSM states:
  - RUN: normal operation.
  - I_MISS: instruction-cache refill in progress.
  - D_MISS: data-cache refill in progress.
- RUN transitions, evaluated each cycle:
  - i_dcache_miss → D_MISS. Data misses win because they belong to the older instruction.
  - Otherwise, i_icache_miss && !i_branch_taken_e → I_MISS. A miss on a wrong-path fetch is ignored.
  - Otherwise, stay in RUN.
- I_MISS and D_MISS:
  - o_mem_req = 1.
  - o_mem_sel = 0 in I_MISS, 1 in D_MISS; stable for the whole request.
  - All four stall outputs = 1.
  - Both flush outputs = 0, so a pending redirect stays frozen in execute.
  - i_mem_ack = 1 → RUN.
- Load-use hazard, evaluated in RUN only:
  - Condition: i_load_instr_e && i_rd_addr_e != 0 && i_rd_addr_e matches i_rs1_addr_d or i_rs2_addr_d.
  - Response: o_stall_fetch = o_stall_decode = 1 and o_flush_exec = 1, for one cycle.
- Branch redirect, evaluated in RUN only: i_branch_taken_e → o_flush_decode = o_flush_exec = 1. It overrides the load-use stall: fetch and decode stalls go to 0.
- Forwarding, combinational and independent of FSM state, shown for rs1 (rs2 is identical):
  - 10 if i_reg_we_m && i_rd_addr_m != 0 && i_rd_addr_m == i_rs1_addr_e.
  - Otherwise 01 if the same test passes for the writeback stage.
  - Otherwise 00.
  - The memory stage has priority over writeback.
- Stall counter:
  - Increments when o_stall_fetch = 1.
  - Holds at all-ones once saturated.
  - Cleared only by reset.

## Timing
- Reset values:
  - State = RUN.
  - o_mem_req = 0, o_mem_sel = 0.
  - o_stall_count = 0.
  - All stall and flush outputs = 0 when the inputs are idle.
- Reset assertion takes effect immediately, without waiting for a clock edge:
  - State forced to RUN.
  - o_mem_req drops at once, even mid-refill.
  - Counter cleared.
- Latency:
  - Stall, flush and forward outputs are combinational from the current state and the inputs.
  - A miss seen in cycle N puts o_mem_req high from cycle N+1.
  - In cycle N (still in RUN), the miss alone does not stall. The cache holds its own output invalid during that cycle.
- Handshake:
  - o_mem_req stays high through the cycle in which i_mem_ack is sampled.
  - The next cycle is RUN: o_mem_req = 0 and the stalls are released.
  - An i_mem_ack seen while in RUN is ignored.
- Simultaneous events:
  - i_icache_miss and i_dcache_miss together → D_MISS. If the instruction miss persists after the data ack, I_MISS follows.
  - A new miss in the cycle after an ack is accepted; RUN spends exactly one cycle there.
  - Branch and load-use in the same cycle → flush only, no stall.
  - Branch taken while in D_MISS → the flush is issued in the first RUN cycle, provided the branch is still asserted.
- Width: rd = 0 never triggers a hazard or forward.

## Test plan
- Load-use:
  - Stimulus: i_load_instr_e = 1, i_rd_addr_e = 5, i_rs2_addr_d = 5, state RUN.
  - Required: o_stall_fetch = o_stall_decode = o_flush_exec = 1 for exactly one cycle; o_stall_count increments by 1.
  - Repeat with i_rd_addr_e = 0: no stall.
- Forwarding priority:
  - Stimulus: i_reg_we_m = i_reg_we_w = 1, i_rd_addr_m = i_rd_addr_w = 7, i_rs1_addr_e = 7.
  - Required: o_forward_rs1 = 10.
  - Then i_reg_we_m = 0: o_forward_rs1 = 01.
- Arbitration:
  - Stimulus: i_icache_miss and i_dcache_miss high in the same cycle.
  - Required: next cycle o_mem_req = 1, o_mem_sel = 1.
  - Pulse i_mem_ack after 4 cycles: one RUN cycle, then o_mem_req = 1, o_mem_sel = 0.
- Wrong-path miss:
  - Stimulus: i_icache_miss = 1 together with i_branch_taken_e = 1.
  - Required: state stays RUN, o_mem_req = 0, o_flush_decode = o_flush_exec = 1.
- Redirect under freeze:
  - Stimulus: in D_MISS, hold i_branch_taken_e = 1.
  - Required: flushes stay 0 and all stalls 1 until ack; in the cycle after ack, o_flush_decode = o_flush_exec = 1.
- Reset mid-refill and saturation:
  - Stimulus: drop i_arst during I_MISS.
  - Required: o_mem_req goes to 0 before the next edge; o_stall_count = 0.
  - With CNT_WIDTH = 4, hold a miss for 20 cycles: the counter stops at 15.
